brush_painter: RTL and testbench
================================

Name: brush_painter

Overview:
- Upstream write-side stage of the pixel store.
- Turns one paint command (cursor centre, colour, brush radius) into a raster sweep of single-pixel write requests (brush, wx, wy, newColor).
- Sits between the MCU command decoder and the pixel store's write port.
- Each pixel is held until the store signals that its write slot is free.

Parameters:
- MAX_COORDINATE, 128, canvas side in pixels; valid coordinates are 0..MAX_COORDINATE-1.
- RADIUS_W, 2, width of the brush radius field; radius range is 0..2^RADIUS_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cmdValid  input  1  paint command present this cycle
- cmdX  input  8  brush centre x
- cmdY  input  8  brush centre y
- cmdColor  input  3  colour code to paint (erase code = 0)
- cmdRadius  input  RADIUS_W  brush radius r; footprint is (2r+1)x(2r+1) before clipping
- wrReady  input  1  pixel store write slot available this cycle
- brush  output  1  write request valid
- wx  output  8  write x
- wy  output  8  write y
- newColor  output  3  write colour
- busy  output  1  sweep in progress or command pending

Behaviour:
- Reset:
  - Asynchronous: all outputs go to 0 immediately.
  - State returns to IDLE; the pending slot is cleared.
  - A sweep interrupted by reset is abandoned; no further writes from it.
- States:
  - IDLE: cmdValid=1 with an in-canvas centre latches the command -> LOAD.
  - LOAD: one cycle. Computes clipped bounds using 9-bit signed arithmetic:
    - x0 = max(cx-r, 0), x1 = min(cx+r, MAX_COORDINATE-1); y0, y1 likewise.
    - Sets wx=x0, wy=y0 -> SWEEP.
  - SWEEP:
    - brush=1.
    - A transfer occurs on a cycle with brush=1 and wrReady=1.
    - After a transfer: wx increments; at x1, wx returns to x0 and wy increments.
    - After the transfer at (x1, y1): if a command is pending -> LOAD with it, else -> IDLE.
- Handshake:
  - wx, wy and newColor are stable while brush=1 and wrReady=0.
  - brush never deasserts mid-sweep except on reset.
- Latency: cmdValid at cycle N (IDLE) -> brush=1 with (x0, y0) at N+2.
- Throughput: one pixel per wrReady=1 cycle.
- Commands arriving while busy:
  - Go into a single-entry pending register.
  - A newer command overwrites an older pending one.
  - No back-pressure on the command side.
- Centre outside the canvas (cmdX or cmdY >= MAX_COORDINATE): command silently dropped, both in IDLE and as a pending command.
- cmdValid in the same cycle as the final transfer: captured as pending, then taken in LOAD on the next cycle.
- busy = (state != IDLE) | pendingValid.
- Clipping:
  - Corner at (0,0) with r=3: 4x4 sweep.
  - Corner at (127,127) with r=3: 4x4 sweep.
  - No coordinate ever wraps below 0 or exceeds 127.
- Write order within a sweep: raster order, rows y0..y1, each row x0..x1.

Optional Feature:
- Macro: BRUSH_ROUND_EN.
- Defined:
  - In SWEEP, pixels with dx^2+dy^2 > r^2+r are skipped (dx = wx-cx, dy = wy-cy). This gives a round footprint.
  - A skipped pixel presents brush=0 for exactly one cycle, then the scan advances regardless of wrReady.
  - The final-pixel rule still applies; (x1, y1) is judged by the same test.
- Undefined: square footprint; every pixel inside the clipped bounds is written.

Decomposition:
- Shared package paint_pkg:
  - MAX_COORDINATE constant.
  - colour code constants (erase, red, green, blue, ...).
  - brush_state_t enum {IDLE, LOAD, SWEEP}.
  - command struct {x, y, color, radius}.
- One sub-module, brush_bounds:
  - Combinational.
  - Inputs: centre, radius.
  - Outputs: clipped x0, x1, y0, y1.
  - Reused by LOAD and by the bench's reference model.

Test Plan:
1. Reset, then cmd (64,64), color=3, r=0, wrReady=1 -> brush=1 at N+2 with (64,64,3), exactly 1 write; busy falls the cycle after.
2. cmd (10,20), r=1, wrReady=1 -> 9 writes in order (9,19)..(11,19), (9,20)..(11,21); no duplicates.
3. cmd (0,127), r=3 -> 16 writes, x 0..3, y 124..127; none outside the canvas.
4. wrReady toggling 1,0,1,0 during an r=1 sweep -> outputs held on 0 cycles; 9 writes in 18 cycles.
5. Second cmd (30,30) mid-sweep, then a third cmd (40,40) -> only (40,40) is painted after the first sweep; cmd (200,5) produces no writes.
6. Reset asserted mid-sweep -> brush=0 in the same cycle; after release with no new cmd, no writes resume.
- BRUSH_ROUND_EN builds: r=2 at (50,50) -> 21 writes; the four corners (48,48), (52,48), (48,52), (52,52) are absent.

Source files
------------

// File: rtl/paint_pkg.sv
// paint_pkg: shared canvas constants, colour codes, brush FSM states and command record
package paint_pkg;
  localparam int MAX_COORDINATE = 128;
  localparam int RADIUS_W = 2;
  localparam logic [2:0] COL_ERASE = 3'd0;
  localparam logic [2:0] COL_RED = 3'd1;
  localparam logic [2:0] COL_GREEN = 3'd2;
  localparam logic [2:0] COL_BLUE = 3'd3;
  localparam logic [2:0] COL_WHITE = 3'd7;
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} brush_state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic [RADIUS_W-1:0] radius;
  } cmd_t;
endpackage

// File: rtl/brush_bounds.sv
// brush_bounds: clips a brush footprint (centre +/- radius) to the canvas in 9-bit signed arithmetic
module brush_bounds
  import paint_pkg::*;
(
  input  logic [7:0]          cx_i,
  input  logic [7:0]          cy_i,
  input  logic [RADIUS_W-1:0] r_i,
  output logic [7:0]          x0_o,
  output logic [7:0]          x1_o,
  output logic [7:0]          y0_o,
  output logic [7:0]          y1_o
);
  function automatic logic [7:0] clip_lo(input logic [7:0] c, input logic [RADIUS_W-1:0] r);
    logic signed [8:0] v;
    v = $signed({1'b0, c}) - $signed(9'(r));
    return v < 0 ? 8'd0 : v[7:0];
  endfunction
  function automatic logic [7:0] clip_hi(input logic [7:0] c, input logic [RADIUS_W-1:0] r);
    logic signed [8:0] v;
    v = $signed({1'b0, c}) + $signed(9'(r));
    return v > $signed(9'(MAX_COORDINATE - 1)) ? 8'(MAX_COORDINATE - 1) : v[7:0];
  endfunction
  assign x0_o = clip_lo(cx_i, r_i);
  assign x1_o = clip_hi(cx_i, r_i);
  assign y0_o = clip_lo(cy_i, r_i);
  assign y1_o = clip_hi(cy_i, r_i);
endmodule

// File: rtl/brush_painter.sv
// brush_painter: expands paint commands into raster pixel writes; BRUSH_ROUND_EN gives a round footprint
module brush_painter
  import paint_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cmdValid,
  input  logic [7:0]          cmdX,
  input  logic [7:0]          cmdY,
  input  logic [2:0]          cmdColor,
  input  logic [RADIUS_W-1:0] cmdRadius,
  input  logic                wrReady,
  output logic                brush,
  output logic [7:0]          wx,
  output logic [7:0]          wy,
  output logic [2:0]          newColor,
  output logic                busy
);
  brush_state_t state_q, state_d;
  cmd_t cur_q, cur_d, pend_q, pend_d, cmd_in;
  logic pend_v_q, pend_v_d;
  logic [7:0] wx_q, wx_d, wy_q, wy_d, x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [7:0] bx0, bx1, by0, by1;
  logic cmd_ok, skip, adv, last, row_end;
  assign cmd_in = {cmdX, cmdY, cmdColor, cmdRadius};
  assign cmd_ok = cmdValid & ({1'b0, cmdX} < 9'(MAX_COORDINATE)) & ({1'b0, cmdY} < 9'(MAX_COORDINATE));
  brush_bounds u_bounds (
    .cx_i(cur_q.x), .cy_i(cur_q.y), .r_i(cur_q.radius),
    .x0_o(bx0), .x1_o(bx1), .y0_o(by0), .y1_o(by1)
  );
`ifdef BRUSH_ROUND_EN
  logic signed [17:0] dx, dy, rr;
  assign dx = $signed(18'(wx_q)) - $signed(18'(cur_q.x));
  assign dy = $signed(18'(wy_q)) - $signed(18'(cur_q.y));
  assign rr = $signed(18'(cur_q.radius)) * $signed(18'(cur_q.radius)) + $signed(18'(cur_q.radius));
  assign skip = (state_q == SWEEP) & (dx * dx + dy * dy > rr);
`else
  assign skip = 1'b0;
`endif
  assign brush = (state_q == SWEEP) & ~skip;
  assign adv = (brush & wrReady) | skip;
  assign row_end = wx_q == x1_q;
  assign last = row_end & (wy_q == y1_q);
  assign wx = wx_q;
  assign wy = wy_q;
  assign newColor = cur_q.color;
  assign busy = (state_q != IDLE) | pend_v_q;
  // next state: latch commands, load clipped bounds, step the raster scan
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    pend_d = cmd_ok ? cmd_in : pend_q;
    pend_v_d = pend_v_q | cmd_ok;
    wx_d = wx_q;
    wy_d = wy_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    case (state_q)
      IDLE: begin
        pend_v_d = 1'b0;
        state_d = cmd_ok ? LOAD : IDLE;
        cur_d = cmd_ok ? cmd_in : cur_q;
      end
      LOAD: begin
        wx_d = bx0;
        wy_d = by0;
        x0_d = bx0;
        x1_d = bx1;
        y1_d = by1;
        state_d = SWEEP;
      end
      SWEEP: begin
        if (adv && last) begin
          state_d = pend_v_d ? LOAD : IDLE;
          cur_d = pend_v_d ? pend_d : cur_q;
          pend_v_d = 1'b0;
        end else if (adv) begin
          wx_d = row_end ? x0_q : wx_q + 8'd1;
          wy_d = row_end ? wy_q + 8'd1 : wy_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any sweep and pending command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      wx_q <= '0;
      wy_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      wx_q <= wx_d;
      wy_q <= wy_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end
endmodule

// File: tb/tb_brush_painter.sv
// tb_brush_painter: scoreboard bench for brush_painter; honours BRUSH_ROUND_EN
module tb_brush_painter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmdValid = 1'b0;
  logic [7:0] cmdX = '0;
  logic [7:0] cmdY = '0;
  logic [2:0] cmdColor = '0;
  logic [1:0] cmdRadius = '0;
  logic wrReady = 1'b0;
  logic brush, busy;
  logic [7:0] wx, wy;
  logic [2:0] newColor;
  int total = 0;
  int bad = 0;
  int writes = 0;
  logic [18:0] exp_q[$];

  brush_painter dut (
    .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdX(cmdX), .cmdY(cmdY),
    .cmdColor(cmdColor), .cmdRadius(cmdRadius), .wrReady(wrReady), .brush(brush),
    .wx(wx), .wy(wy), .newColor(newColor), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every transfer must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && brush && wrReady) begin
      writes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write: got (%0d,%0d,c%0d) expected none", wx, wy, newColor);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({wx, wy, newColor} != e) begin
          bad++;
          $display("FAIL write: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                   wx, wy, newColor, e[18:11], e[10:3], e[2:0]);
        end
      end
    end
  end

  task automatic push_sweep(input int cx, input int cy, input int r, input int col);
    for (int y = (cy - r < 0 ? 0 : cy - r); y <= (cy + r > 127 ? 127 : cy + r); y++)
      for (int x = (cx - r < 0 ? 0 : cx - r); x <= (cx + r > 127 ? 127 : cx + r); x++) begin
`ifdef BRUSH_ROUND_EN
        if ((x - cx) * (x - cx) + (y - cy) * (y - cy) > r * r + r) continue;
`endif
        exp_q.push_back({8'(x), 8'(y), 3'(col)});
      end
  endtask

  task automatic issue(input int x, input int y, input int col, input int r);
    cmdValid = 1'b1;
    cmdX = 8'(x);
    cmdY = 8'(y);
    cmdColor = 3'(col);
    cmdRadius = 2'(r);
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int w0;
    logic [7:0] hx, hy;
    #1;
    chk("rst_brush", int'(brush), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wx", int'(wx), 0);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    // 1: single pixel, latency N+2, busy drops right after
    wrReady = 1'b1;
    w0 = writes;
    push_sweep(64, 64, 0, 3);
    issue(64, 64, 3, 0);
    chk("t1_load_brush", int'(brush), 0);
    chk("t1_load_busy", int'(busy), 1);
    cycles(1);
    chk("t1_brush", int'(brush), 1);
    chk("t1_wx", int'(wx), 64);
    chk("t1_wy", int'(wy), 64);
    chk("t1_col", int'(newColor), 3);
    cycles(1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_brush_after", int'(brush), 0);
    chk("t1_writes", writes - w0, 1);
    // 2: 3x3 sweep in raster order
    w0 = writes;
    push_sweep(10, 20, 1, 2);
    issue(10, 20, 2, 1);
    wait_idle(100);
    chk("t2_writes", writes - w0, 9);
    // 3: corner clipping
    w0 = writes;
    push_sweep(0, 127, 3, 5);
    issue(0, 127, 5, 3);
    wait_idle(100);
`ifdef BRUSH_ROUND_EN
    chk("t3_writes", writes - w0, 13);
`else
    chk("t3_writes", writes - w0, 16);
`endif
    // 4: alternating wrReady, outputs held on stalled cycles
    w0 = writes;
    push_sweep(20, 20, 1, 6);
    issue(20, 20, 6, 1);
    cycles(1);
    chk("t4_brush_start", int'(brush), 1);
    for (int i = 0; i < 18; i++) begin
      wrReady = (i % 2 == 0);
      hx = wx;
      hy = wy;
      @(posedge clk); #1;
      if (i % 2 == 1 && i < 16) begin
        chk("t4_hold_x", int'(wx), int'(hx));
        chk("t4_hold_y", int'(wy), int'(hy));
        chk("t4_hold_brush", int'(brush), 1);
      end
    end
    chk("t4_writes", writes - w0, 9);
    chk("t4_busy", int'(busy), 0);
    // 5: pending overwrite, out-of-canvas pending dropped
    wrReady = 1'b0;
    w0 = writes;
    push_sweep(60, 60, 1, 1);
    issue(60, 60, 1, 1);
    issue(30, 30, 2, 1);
    issue(40, 40, 4, 1);
    issue(200, 5, 7, 1);
    chk("t5_busy", int'(busy), 1);
    push_sweep(40, 40, 1, 4);
    wrReady = 1'b1;
    wait_idle(100);
    chk("t5_writes", writes - w0, 18);
    w0 = writes;
    issue(200, 5, 7, 0);
    chk("t5_drop_busy", int'(busy), 0);
    cycles(5);
    chk("t5_drop_writes", writes - w0, 0);
    // 7: command in the same cycle as the final transfer
    w0 = writes;
    push_sweep(5, 5, 0, 2);
    push_sweep(7, 7, 0, 5);
    issue(5, 5, 2, 0);
    cycles(1);
    issue(7, 7, 5, 0);
    wait_idle(50);
    chk("t7_writes", writes - w0, 2);
`ifdef BRUSH_ROUND_EN
    // round footprint r=2
    w0 = writes;
    push_sweep(50, 50, 2, 3);
    issue(50, 50, 3, 2);
    wait_idle(100);
    chk("round_writes", writes - w0, 21);
`endif
    chk("queue_drained", exp_q.size(), 0);
    // 6: reset mid-sweep
    w0 = writes;
    push_sweep(64, 64, 3, 7);
    issue(64, 64, 7, 3);
    cycles(4);
    chk("t6_brush_pre", int'(brush), 1);
    reset = 1'b1;
    #1;
    chk("t6_brush", int'(brush), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_wx", int'(wx), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    w0 = writes;
    cycles(30);
    chk("t6_no_resume", writes - w0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
